// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bundle for the GPU host port: AW/W/B/AR/R channels with
// 32-bit data, 4-bit strobe and ADDR_WIDTH-bit byte addresses.
interface axi_burst_master_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst initiator: one command becomes one AW+W+B or AR+R burst.
// W and R data pass combinationally between the local streams and the bus;
// all control outputs come from registers.
module axi_burst_master #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  gpu_clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            resp,
    axi_burst_master_if.master    M_AXI
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_awvalid;
    logic                  r_arvalid;
    logic                  r_bready;
    logic                  r_in_w;
    logic                  r_in_r;
    logic                  r_done;
    logic [1:0]            r_resp;
    logic [1:0]            r_rstat;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;

    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_last_beat;
    logic [1:0]            w_rstat_next;
    logic                  w_unused_addr_lsb;

    assign w_w_hs            = r_in_w & wr_valid & M_AXI.wready;
    assign w_r_hs            = r_in_r & M_AXI.rvalid & rd_ready;
    assign w_last_beat       = (r_cnt == r_len);
    // First non-OKAY response seen so far, including the current beat.
    assign w_rstat_next      = (r_rstat == 2'b00) ? M_AXI.rresp : r_rstat;
    // Address is word-aligned internally; the two low bits are dropped.
    assign w_unused_addr_lsb = ^cmd_addr[1:0];

    // Burst sequencing: command capture, address phases, beat counting, completion.
    always_ff @(posedge gpu_clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_in_w      <= 1'b0;
            r_in_r      <= 1'b0;
            r_done      <= 1'b0;
            r_resp      <= 2'b00;
            r_rstat     <= 2'b00;
            r_cnt       <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_len       <= cmd_len;
                        r_cnt       <= 8'd0;
                        r_rstat     <= 2'b00;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_state   <= S_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (M_AXI.awready) begin
                        r_awvalid <= 1'b0;
                        r_in_w    <= 1'b1;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (w_w_hs) begin
                        if (w_last_beat) begin
                            r_in_w   <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_B;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_B: begin
                    if (M_AXI.bvalid) begin
                        r_bready    <= 1'b0;
                        r_resp      <= M_AXI.bresp;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (M_AXI.arready) begin
                        r_arvalid <= 1'b0;
                        r_in_r    <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (w_r_hs) begin
                        r_rstat <= w_rstat_next;
                        if (M_AXI.rlast) begin
                            // A last beat that arrives early or late is a slave error.
                            r_resp      <= w_last_beat ? w_rstat_next : 2'b10;
                            r_in_r      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign done          = r_done;
    assign resp          = r_resp;

    assign M_AXI.awaddr  = r_addr;
    assign M_AXI.awlen   = r_len;
    assign M_AXI.awsize  = 3'b010;
    assign M_AXI.awburst = 2'b01;
    assign M_AXI.awlock  = 1'b0;
    assign M_AXI.awcache = 4'b0000;
    assign M_AXI.awprot  = 3'b000;
    assign M_AXI.awvalid = r_awvalid;

    assign M_AXI.wdata   = wr_data;
    assign M_AXI.wstrb   = wr_strb;
    assign M_AXI.wvalid  = r_in_w & wr_valid;
    assign M_AXI.wlast   = r_in_w & w_last_beat;
    assign wr_ready      = r_in_w & M_AXI.wready;

    assign M_AXI.bready  = r_bready;

    assign M_AXI.araddr  = r_addr;
    assign M_AXI.arlen   = r_len;
    assign M_AXI.arsize  = 3'b010;
    assign M_AXI.arburst = 2'b01;
    assign M_AXI.arlock  = 1'b0;
    assign M_AXI.arcache = 4'b0000;
    assign M_AXI.arprot  = 3'b000;
    assign M_AXI.arvalid = r_arvalid;

    assign rd_valid      = r_in_r & M_AXI.rvalid;
    assign M_AXI.rready  = r_in_r & rd_ready;
    assign rd_data       = M_AXI.rdata;
    assign rd_last       = r_in_r & M_AXI.rlast;
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: table of directed commands, a reset-mid-burst
// sequence and randomized commands, each checked against a command-level model.
module tb_axi_burst_master;
    logic        gpu_clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  resp;

    axi_burst_master_if #(.ADDR_WIDTH(12)) M_AXI ();

    axi_burst_master #(.ADDR_WIDTH(12)) dut (
        .gpu_clk   (gpu_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .resp      (resp),
        .M_AXI     (M_AXI)
    );

    always #5 gpu_clk = ~gpu_clk;

    typedef struct {
        bit          write;
        logic [11:0] addr;
        int          len;
        int          awstall;   // cycles AW/AR ready is held low while valid is up
        bit          wrand;     // random wready / random rvalid start
        bit          rdtoggle;  // rd_ready toggles every other cycle
        int          last_at;   // beat on which the slave raises rlast
        int          err_beat;  // beat carrying err_code on rresp, -1 for none
        logic [1:0]  err_code;
        logic [1:0]  bresp;
        logic [31:0] base;      // data of beat i is base + i
        logic [3:0]  strb;
        logic [11:0] exp_addr;
        logic [1:0]  exp_resp;
        int          exp_beats;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Command-level status rule: write reports bresp; read reports SLVERR if the
    // last beat is not beat len, otherwise the first non-OKAY rresp delivered.
    function automatic logic [1:0] ref_resp(input vec_t v);
        if (v.write) return v.bresp;
        if (v.last_at != v.len) return 2'b10;
        if (v.err_beat >= 0 && v.err_beat <= v.last_at) return v.err_code;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h0; cmd_len = 8'h0;
        wr_valid = 1'b0; wr_data = 32'h0; wr_strb = 4'h0; rd_ready = 1'b0;
        M_AXI.awready = 1'b0; M_AXI.wready = 1'b0;
        M_AXI.bvalid = 1'b0; M_AXI.bresp = 2'b00;
        M_AXI.arready = 1'b0; M_AXI.rvalid = 1'b0; M_AXI.rdata = 32'h0;
        M_AXI.rresp = 2'b00; M_AXI.rlast = 1'b0;
    endtask

    // Runs one command as stream source/sink and AXI slave, checking every cycle.
    task automatic do_cmd(input vec_t v);
        int beat_w = 0, beat_r = 0, aw_cnt = 0, ar_cnt = 0, cyc = 0;
        bit sent = 0, aw_done = 0, ar_done = 0, w_done = 0, b_done = 0, r_done = 0;
        bit fin_hs = 0, fin = 0, r_hold = 0;
        while (!fin && cyc < 3000) begin
            @(negedge gpu_clk);
            cyc++;
            if (fin_hs) begin
                chk("done_pulse", done, 1);
                chk("resp", resp, v.exp_resp);
                chk("cmd_ready_at_done", cmd_ready, 1);
                fin = 1;
                idle_inputs();
            end else begin
                cmd_valid = !sent; cmd_write = v.write; cmd_addr = v.addr; cmd_len = 8'(v.len);
                M_AXI.awready = (aw_cnt >= v.awstall);
                M_AXI.arready = (ar_cnt >= v.awstall);
                M_AXI.wready  = v.wrand ? 1'($urandom_range(0, 1)) : 1'b1;
                wr_valid = v.write && (beat_w <= v.len);
                wr_data  = v.base + 32'(beat_w);
                wr_strb  = v.strb;
                M_AXI.bvalid = w_done && !b_done;
                M_AXI.bresp  = v.bresp;
                M_AXI.rvalid = ar_done && !r_done && (r_hold || !v.wrand || ($urandom_range(0, 1) == 1));
                M_AXI.rdata  = v.base + 32'(beat_r);
                M_AXI.rlast  = (beat_r == v.last_at);
                M_AXI.rresp  = (beat_r == v.err_beat) ? v.err_code : 2'b00;
                rd_ready = v.rdtoggle ? cyc[0] : 1'b1;
                #1;
                chk("cmd_ready", cmd_ready, !sent);
                chk("done_idle", done, 0);
                chk("awvalid", M_AXI.awvalid, v.write && sent && !aw_done);
                chk("arvalid", M_AXI.arvalid, !v.write && sent && !ar_done);
                chk("wvalid", M_AXI.wvalid, aw_done && !w_done && wr_valid);
                chk("wr_ready", wr_ready, aw_done && !w_done && M_AXI.wready);
                chk("bready", M_AXI.bready, w_done && !b_done);
                chk("rready", M_AXI.rready, ar_done && !r_done && rd_ready);
                chk("rd_valid", rd_valid, ar_done && !r_done && M_AXI.rvalid);
                if (M_AXI.awvalid) begin
                    chk("awaddr", M_AXI.awaddr, v.exp_addr);
                    chk("awlen", M_AXI.awlen, 32'(v.len));
                    chk("aw_fixed", {M_AXI.awburst, M_AXI.awsize, M_AXI.awlock, M_AXI.awcache, M_AXI.awprot},
                        {2'b01, 3'b010, 1'b0, 4'b0000, 3'b000});
                    aw_cnt++;
                end
                if (M_AXI.arvalid) begin
                    chk("araddr", M_AXI.araddr, v.exp_addr);
                    chk("arlen", M_AXI.arlen, 32'(v.len));
                    chk("ar_fixed", {M_AXI.arburst, M_AXI.arsize, M_AXI.arlock, M_AXI.arcache, M_AXI.arprot},
                        {2'b01, 3'b010, 1'b0, 4'b0000, 3'b000});
                    ar_cnt++;
                end
                if (M_AXI.awvalid && M_AXI.awready) aw_done = 1;
                if (M_AXI.arvalid && M_AXI.arready) ar_done = 1;
                if (M_AXI.wvalid && M_AXI.wready) begin
                    chk("wdata", M_AXI.wdata, v.base + 32'(beat_w));
                    chk("wstrb", M_AXI.wstrb, v.strb);
                    chk("wlast", M_AXI.wlast, beat_w == v.len);
                    if (beat_w == v.len) w_done = 1;
                    beat_w++;
                end
                if (M_AXI.bvalid && M_AXI.bready) begin
                    b_done = 1; fin_hs = 1;
                end
                r_hold = M_AXI.rvalid && !M_AXI.rready;
                if (rd_valid && rd_ready) begin
                    chk("rd_data", rd_data, v.base + 32'(beat_r));
                    chk("rd_last", rd_last, beat_r == v.last_at);
                    if (beat_r == v.last_at) begin
                        r_done = 1; fin_hs = 1;
                    end
                    beat_r++;
                end
                if (cmd_valid && cmd_ready) sent = 1;
            end
        end
        chk("cmd_complete", fin, 1);
        chk("beats", v.write ? beat_w : beat_r, v.exp_beats);
        @(negedge gpu_clk);
        chk("done_one_cycle", done, 0);
        chk("resp_held", resp, v.exp_resp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        vec_t rv;
        bit   hs_c, hs_w;
        int   n_w;

        //          wr    addr     len  stl wr   tg   last err  ecode  bresp  base       strb   exp_addr  resp   beats
        tbl[0] = '{1'b1, 12'h010,   3, 0, 1'b0, 1'b0,   3, -1, 2'b00, 2'b00, 32'hA0,   4'hF, 12'h010, 2'b00,   4};
        tbl[1] = '{1'b0, 12'h100,   7, 0, 1'b0, 1'b1,   7, -1, 2'b00, 2'b00, 32'h0,    4'hF, 12'h100, 2'b00,   8};
        tbl[2] = '{1'b1, 12'h010,   3, 5, 1'b1, 1'b0,   3, -1, 2'b00, 2'b00, 32'hA0,   4'hF, 12'h010, 2'b00,   4};
        tbl[3] = '{1'b0, 12'h020,   3, 0, 1'b0, 1'b0,   1, -1, 2'b00, 2'b00, 32'h0,    4'hF, 12'h020, 2'b10,   2};
        tbl[4] = '{1'b0, 12'h030,   3, 0, 1'b0, 1'b0,   3,  2, 2'b10, 2'b00, 32'h0,    4'hF, 12'h030, 2'b10,   4};
        tbl[5] = '{1'b1, 12'h080,   0, 0, 1'b0, 1'b0,   0, -1, 2'b00, 2'b00, 32'h55,   4'hF, 12'h080, 2'b00,   1};
        tbl[6] = '{1'b1, 12'h0C4,   2, 1, 1'b0, 1'b0,   2, -1, 2'b00, 2'b10, 32'h77,   4'h3, 12'h0C4, 2'b10,   3};
        tbl[7] = '{1'b0, 12'h400, 255, 0, 1'b0, 1'b0, 255, -1, 2'b00, 2'b00, 32'h1000, 4'hF, 12'h400, 2'b00, 256};
        tbl[8] = '{1'b1, 12'h013,   1, 0, 1'b0, 1'b0,   1, -1, 2'b00, 2'b00, 32'hB0,   4'hF, 12'h010, 2'b00,   2};
        tbl[9] = '{1'b0, 12'h200,   4, 2, 1'b0, 1'b1,   4,  0, 2'b11, 2'b00, 32'h300,  4'hF, 12'h200, 2'b11,   5};

        // Reset state, with stream inputs active so output gating is exercised.
        idle_inputs();
        reset = 1'b1;
        wr_valid = 1'b1; rd_ready = 1'b1;
        repeat (3) @(negedge gpu_clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {M_AXI.awvalid, M_AXI.arvalid, M_AXI.wvalid, M_AXI.wlast, rd_valid}, 0);
        chk("rst_readies", {M_AXI.bready, M_AXI.rready, wr_ready}, 0);
        chk("rst_done_resp", {done, resp}, 0);
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("cmd_ready_first_cycle", cmd_ready, 0);
        @(negedge gpu_clk);
        chk("cmd_ready_rise", cmd_ready, 1);

        for (int i = 0; i < 10; i++) do_cmd(tbl[i]);

        // Reset while W beat 2 of a len-7 write is on the bus.
        @(negedge gpu_clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_len = 8'd7;
        M_AXI.awready = 1'b1; M_AXI.wready = 1'b1;
        wr_valid = 1'b1; wr_strb = 4'hF; wr_data = 32'hC0;
        n_w = 0;
        for (int k = 0; k < 30 && n_w < 2; k++) begin
            #1;
            hs_c = cmd_valid && cmd_ready;
            hs_w = M_AXI.wvalid && M_AXI.wready;
            @(negedge gpu_clk);
            if (hs_c) cmd_valid = 1'b0;
            if (hs_w) begin
                n_w++;
                wr_data = 32'hC0 + 32'(n_w);
            end
        end
        chk("rst_mid_beats_before", n_w, 2);
        #1;
        chk("rst_mid_beat2_offered", M_AXI.wvalid, 1);
        reset = 1'b1;
        @(negedge gpu_clk);
        chk("rst_mid_valids", {M_AXI.awvalid, M_AXI.arvalid, M_AXI.wvalid, M_AXI.wlast, rd_valid}, 0);
        chk("rst_mid_readies", {M_AXI.bready, M_AXI.rready, wr_ready, cmd_ready}, 0);
        chk("rst_mid_no_done", done, 0);
        idle_inputs();
        @(negedge gpu_clk);
        chk("rst_mid_no_done_2", done, 0);
        reset = 1'b0;
        repeat (2) @(negedge gpu_clk);
        rv = '{1'b1, 12'h208, 2, 1, 1'b0, 1'b0, 2, -1, 2'b00, 2'b00, 32'hD0, 4'hF, 12'h208, 2'b00, 3};
        do_cmd(rv);

        // Randomized commands against the command-level model.
        for (int i = 0; i < 20; i++) begin
            rv.write    = 1'($urandom_range(0, 1));
            rv.addr     = 12'($urandom_range(0, 4095));
            rv.len      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 15));
            rv.awstall  = int'($urandom_range(0, 3));
            rv.wrand    = 1'($urandom_range(0, 1));
            rv.rdtoggle = 1'($urandom_range(0, 1));
            rv.last_at  = (!rv.write && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, rv.len)) : rv.len;
            rv.err_beat = (!rv.write && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, rv.len)) : -1;
            rv.err_code = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
            rv.bresp    = 2'($urandom_range(0, 3));
            rv.base     = $urandom;
            rv.strb     = 4'($urandom_range(0, 15));
            rv.exp_addr = {rv.addr[11:2], 2'b00};
            rv.exp_resp = ref_resp(rv);
            rv.exp_beats = rv.write ? rv.len + 1 : rv.last_at + 1;
            do_cmd(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

AXI4 burst initiator for the GPU's 32-bit host register/memory port. It turns single commands (address, beat count, direction) into one INCR burst on an AXI4 master interface. Write data comes in on a valid/ready stream and read data goes out on one. It drives a `Gpu`-style AXI4 slave from on-fabric logic such as a command processor or a bench driver, so the slave's burst handling can be exercised end to end.

## Interface
- `ADDR_WIDTH`, 12: byte-address width of `M_AXI_araddr`/`M_AXI_awaddr`.
- `gpu_clk` in 1: sole clock; all ports are synchronous to it.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_WIDTH: start byte address; bits [1:0] are ignored and forced to 0.
- `cmd_len` in 8: beats minus one (AXI `len` encoding, 0..255).
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in 32 / `wr_strb` in 4: write-data stream.
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out 32 / `rd_last` out 1: read-data stream.
- `done` out 1: one-cycle pulse at the end of each command.
- `resp` out 2: status of the last completed command, held until the next `done`.
- `M_AXI_aw*`, `M_AXI_w*`, `M_AXI_b*`, `M_AXI_ar*`, `M_AXI_r*`: full AXI4 master channels, widths mirroring the `Gpu` slave port.
  - addr is ADDR_WIDTH; burst, cache, len, lock, prot and size as AXI4.
  - data is 32 bits, strobe 4 bits, resp 2 bits.

## Operation
- State machine: IDLE, AW, W, B, AR, R.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`, latch addr, len and dir, then go to AW (write) or AR (read).
- Constant AXI fields:
  - burst = 2'b01 (INCR)
  - size = 3'b010 (4 bytes)
  - cache = 4'b0000, lock = 0, prot = 3'b000
- AW: `awvalid`=1 with the latched addr and len, held stable until `awready`, then go to W.
  - W never starts before the AW handshake.
- W:
  - `M_AXI_wvalid`=`wr_valid`, `wr_ready`=`M_AXI_wready`; wdata and wstrb pass straight through.
  - An 8-bit beat counter starts at 0 and increments on each W handshake.
  - `wlast`=1 exactly when count == len.
  - On the handshake with `wlast`, go to B.
- B: `bready`=1. On the B handshake, set `resp`=`bresp`, pulse `done`, and go to IDLE.
- AR: `arvalid`=1 with the latched addr and len until `arready`, then go to R.
- R:
  - `rd_valid`=`M_AXI_rvalid`, `M_AXI_rready`=`rd_ready`, `rd_data`=`rdata`, `rd_last`=`rlast`.
  - The beat counter increments on each R handshake.
  - The running status latches the first non-OKAY `rresp`.
  - On the handshake with `rlast`, pulse `done` and go to IDLE.
  - If the `rlast` beat arrives with count != len, final `resp` = 2'b10 (SLVERR).
- `wr_ready`=0 outside W; `rd_valid`=0 outside R.
- 4 KB crossing is the caller's responsibility; the block does not split bursts.

## Timing
- While `reset` is high and on the first cycle after it:
  - Outputs are 0: all valids, `bready`, `rready`, `cmd_ready`, `done`, `resp`=2'b00, `wlast`.
  - State is IDLE.
- `cmd_ready` rises on the first edge after `reset` deasserts.
- Reset mid-burst abandons the transaction immediately. Valids drop on the next edge; no `done` is issued.
- Command handshake to `awvalid`/`arvalid` high: 1 cycle.
  - AW/AR handshake to W/R acceptance: 0 cycles (the state changes on the handshake edge).
- W and R are fully combinational pass-through, giving 1 beat per cycle at full throughput.
- `done` pulses in the cycle after the B handshake (write) or the last R handshake (read). `cmd_ready` is high in that same cycle.
- Back-to-back commands: 1 idle cycle minimum between bursts.
- len = 0: single beat, with `wlast`/expected `rlast` on beat 0.
- len = 255: 256 beats; the counter reaches 255 and does not wrap within the burst.
- AXI stability: `awaddr`/`awlen`/`araddr`/`arlen` are held while their valid is high and ready is low. Valids never drop without a handshake.

## Test plan
- Write burst, addr 0x010, len 3, data 0xA0..0xA3, strb 0xF, slave always ready:
  - awaddr=0x010, awlen=3; 4 W beats with `wlast` on beat 3 only.
  - `done` 1 cycle after the B handshake; `resp`=00.
- Read burst, addr 0x100, len 7, slave returns 0x0..0x7 with `rlast` on beat 7, and `rd_ready` toggled every other cycle:
  - `rd_data` sequence is 0..7 with no loss or duplication; `rready` tracks `rd_ready`.
  - `done` after beat 7; `resp`=00.
- Slave stalls `awready` 5 cycles and `wready` randomly:
  - awaddr/awlen are stable throughout the stall; `wvalid` stays low until the AW handshake.
  - All 4 beats are delivered intact.
- Read len 3 where the slave asserts `rlast` on beat 1 → `done` after beat 1 with `resp`=10. A separate read with `rresp`=10 on beat 2 → `resp`=10.
- Edge lengths:
  - len 0 write: single beat with `wlast`=1.
  - len 255 read: 256 beats, `done` only after beat 255.
  - `cmd_addr`=0x013 is issued as 0x010.
- Assert `reset` during W beat 2 of a len-7 write:
  - Next edge: all valids 0 and no `done`.
  - A following command issues cleanly with awaddr equal to the new address.
